// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel LED PWM with double-buffered duty, breathe/blink modes,
// button debouncer and a delayed board reset release.
module rgb_pwm_lane #(
  parameter int   W  = 8,
  parameter logic AL = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wr_duty,
  input  logic         period_end,
  input  logic [W-1:0] cnt,
  input  logic [1:0]   mode,
  input  logic [W-1:0] ramp,
  input  logic         blink_phase,
  output logic         led
);
  logic [W-1:0]   r_shadow, r_active, w_eff;
  logic [2*W-1:0] w_prod;
  logic           r_led;

  assign w_prod = {{W{1'b0}}, r_active} * {{W{1'b0}}, ramp};

  always_comb begin
    w_eff = '0;
    case (mode)
      2'd1:    w_eff = r_active;
      2'd2:    w_eff = w_prod[2*W-1:W];
      2'd3:    w_eff = blink_phase ? r_active : '0;
      default: w_eff = '0;
    endcase
  end

  // Active duty only changes at the period boundary, taking the pre-write shadow.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_led    <= AL;
    end else begin
      if (wr)         r_shadow <= wr_duty;
      if (period_end) r_active <= r_shadow;
      r_led <= (cnt < w_eff) ^ AL;
    end
  end

  assign led = r_led;
endmodule

module rgb_pwm_ctrl #(
  parameter int          CHANNELS   = 3,
  parameter int          PWM_WIDTH  = 8,
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter int          RST_CYCLES = 1024,
  parameter int          BLINK_LOG2 = 6,
  parameter int          ACTIVE_LOW = 0,
  localparam int         CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [CW-1:0]        wr_chan,
  input  logic [PWM_WIDTH-1:0] wr_duty,
  input  logic [1:0]           mode,
  input  logic                 usr_btn,
  output logic [CHANNELS-1:0]  led,
  output logic                 btn_level,
  output logic                 btn_press,
  output logic                 rst_n,
  output logic                 period_end
);
  localparam int             RCW = $clog2(RST_CYCLES + 1);
  localparam logic [PWM_WIDTH-1:0] ONE = 1;

  logic [PWM_WIDTH-1:0]  r_cnt, r_ramp;
  logic                  r_dir_dn;
  logic [BLINK_LOG2-1:0] r_bcnt;
  logic                  r_phase;
  logic [1:0]            r_sync;
  logic [15:0]           r_deb;
  logic                  r_lvl, r_press, r_rstn;
  logic [RCW-1:0]        r_rcnt;
  logic                  w_pe;

  assign w_pe = (r_cnt == '1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_ramp   <= '0;
      r_dir_dn <= 1'b0;
      r_bcnt   <= '0;
      r_phase  <= 1'b0;
    end else begin
      r_cnt <= r_cnt + ONE;
      if (w_pe) begin
        // Triangle ramp turns around at the rails without overshoot.
        if (!r_dir_dn) begin
          r_ramp <= r_ramp + ONE;
          if (r_ramp == ~ONE) r_dir_dn <= 1'b1;
        end else begin
          r_ramp <= r_ramp - ONE;
          if (r_ramp == ONE) r_dir_dn <= 1'b0;
        end
        r_bcnt <= r_bcnt + 1'b1;
        if (r_bcnt == '1) r_phase <= ~r_phase;
      end
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    logic w_wr;
    assign w_wr = wr_en && (wr_chan == CW'(gi));
    rgb_pwm_lane #(.W(PWM_WIDTH), .AL(ACTIVE_LOW != 0)) u_lane (
      .clock       (clock),
      .reset       (reset),
      .wr          (w_wr),
      .wr_duty     (wr_duty),
      .period_end  (w_pe),
      .cnt         (r_cnt),
      .mode        (mode),
      .ramp        (r_ramp),
      .blink_phase (r_phase),
      .led         (led[gi])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync  <= '0;
      r_deb   <= '0;
      r_lvl   <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], usr_btn};
      r_press <= 1'b0;
      if (r_sync[1] == r_lvl) begin
        r_deb <= '0;
      end else if (r_deb == DEB_CYCLES - 16'd1) begin
        r_deb   <= '0;
        r_lvl   <= r_sync[1];
        r_press <= r_sync[1];
      end else begin
        r_deb <= r_deb + 16'd1;
      end
    end
  end

  // Saturates once released so rst_n holds high until the next reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rcnt <= '0;
      r_rstn <= 1'b0;
    end else if (!r_rstn) begin
      r_rcnt <= r_rcnt + 1'b1;
      if (r_rcnt == RCW'(RST_CYCLES - 1)) r_rstn <= 1'b1;
    end
  end

  assign btn_level  = r_lvl;
  assign btn_press  = r_press;
  assign rst_n      = r_rstn;
  assign period_end = w_pe;
endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Scoreboard bench for rgb_pwm_ctrl: per-period high-time counts against a
// cycle-count based model of ramp and blink phase.
module tb_rgb_pwm_ctrl;
  localparam int BL = 2;

  logic       clock = 1'b0, reset = 1'b1, wr_en = 1'b0, usr_btn = 1'b0;
  logic [1:0] wr_chan = '0, mode = 2'd1;
  logic [7:0] wr_duty = '0;
  logic [2:0] led, led_al;
  logic       btn_level, btn_press, rst_n, period_end;
  logic       al_lvl, al_press, al_rstn, al_pe;

  rgb_pwm_ctrl #(.CHANNELS(3), .PWM_WIDTH(8), .DEB_CYCLES(16'd8), .RST_CYCLES(16),
                 .BLINK_LOG2(BL), .ACTIVE_LOW(0)) u_dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_chan(wr_chan), .wr_duty(wr_duty),
    .mode(mode), .usr_btn(usr_btn), .led(led), .btn_level(btn_level),
    .btn_press(btn_press), .rst_n(rst_n), .period_end(period_end));

  rgb_pwm_ctrl #(.CHANNELS(3), .PWM_WIDTH(8), .DEB_CYCLES(16'd8), .RST_CYCLES(16),
                 .BLINK_LOG2(BL), .ACTIVE_LOW(1)) u_dut_al (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_chan(wr_chan), .wr_duty(wr_duty),
    .mode(mode), .usr_btn(usr_btn), .led(led_al), .btn_level(al_lvl),
    .btn_press(al_press), .rst_n(al_rstn), .period_end(al_pe));

  always #5 clock = ~clock;

  // Cycles since reset release; the PWM counter must equal mc % 256.
  int mc;
  always @(posedge clock) begin
    if (reset) mc <= 0;
    else       mc <= mc + 1;
  end

  int n_chk = 0, n_pass = 0;
  int sb_q[$];
  int duty_m[3] = '{0, 0, 0};
  int mode_m = 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic sb_pop_chk(input string tag, input int got);
    if (sb_q.size() == 0) chk({tag, "_noexp"}, got, -1);
    else chk(tag, got, sb_q.pop_front());
  endtask

  function automatic int exp_eff(input int md, input int d, input int n);
    int r;
    r = n % 510;
    if (r > 255) r = 510 - r;
    case (md)
      0:       return 0;
      1:       return d;
      2:       return (d * r) >> 8;
      default: return ((n >> BL) & 1) ? d : 0;
    endcase
  endfunction

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic expect_one(input int n);
    for (int c = 0; c < 3; c++) sb_q.push_back(exp_eff(mode_m, duty_m[c], n));
    sb_q.push_back(0);
  endtask

  task automatic wait_pe();
    int k = 0;
    while (!period_end && k < 600) begin step(); k++; end
    chk("pe_seen", int'(period_end), 1);
    chk("pe_phase", mc % 256, 255);
  endtask

  // Called on a period_end sample; counts led high cycles per following period.
  task automatic measure(input int np);
    int h[3];
    int bad;
    step();
    for (int p = 0; p < np; p++) begin
      h = '{0, 0, 0};
      bad = 0;
      for (int k = 0; k < 256; k++) begin
        step();
        for (int c = 0; c < 3; c++) h[c] += int'(led[c]);
        if (led_al !== ~led) bad++;
      end
      for (int c = 0; c < 3; c++) sb_pop_chk($sformatf("high_ch%0d_p%0d", c, p), h[c]);
      sb_pop_chk("al_inverse", bad);
    end
  endtask

  task automatic wr(input int ch, input int d);
    wr_en = 1'b1; wr_chan = 2'(ch); wr_duty = 8'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic check_rstn_release();
    int lo = 0;
    reset = 1'b0;
    while (!rst_n && lo < 100) begin lo++; step(); end
    chk("rstn_low_cycles", lo, 16);
  endtask

  task automatic btn_phase(input string tag, input int cycles, input int toggle,
                           input int exp_lvl, input int exp_press);
    int pr = 0, hi = 0;
    for (int k = 0; k < cycles; k++) begin
      if (toggle > 0 && k % toggle == 0) usr_btn = ~usr_btn;
      step();
      pr += int'(btn_press);
      hi += int'(btn_level);
    end
    chk({tag, "_level"}, int'(btn_level), exp_lvl);
    chk({tag, "_press"}, pr, exp_press);
    if (toggle > 0) chk({tag, "_level_hi"}, hi, 0);
  endtask

  initial begin
    int n0;
    repeat (3) step();
    chk("rst_led", int'(led), 0);
    chk("rst_led_al", int'(led_al), 7);
    chk("rst_flags", int'({period_end, btn_level, btn_press, rst_n}), 0);
    check_rstn_release();

    begin
      int sp = 0;
      wait_pe();
      do begin step(); sp++; end while (!period_end && sp < 600);
      chk("period_len", sp, 256);
    end

    // Static duties: 0x40 / 0x00 / 0xFF.
    wr(0, 8'h40); wr(1, 8'h00); wr(2, 8'hFF);
    duty_m = '{64, 0, 255};
    wait_pe();
    expect_one((mc + 1) / 256);
    measure(1);

    // Shadow write mid-period to ch1 stays invisible until the next boundary.
    wait_pe();
    n0 = (mc + 1) / 256;
    expect_one(n0);
    duty_m[1] = 128;
    expect_one(n0 + 1);
    fork
      measure(2);
      begin repeat (11) step(); wr(1, 8'h80); end
    join

    // Out-of-range channel write is dropped.
    wr(3, 8'h11);
    wait_pe();
    expect_one((mc + 1) / 256);
    measure(1);

    mode = 2'd0; mode_m = 0;
    wait_pe();
    expect_one((mc + 1) / 256);
    measure(1);

    mode = 2'd3; mode_m = 3;
    wait_pe();
    n0 = (mc + 1) / 256;
    for (int p = 0; p < 8; p++) expect_one(n0 + p);
    measure(8);

    // Breathe across the top of the ramp.
    mode = 2'd2; mode_m = 2;
    for (int k = 0; k < 400; k++) begin
      wait_pe();
      if ((mc + 1) / 256 >= 254) break;
      step();
    end
    n0 = (mc + 1) / 256;
    chk("breathe_start", n0, 254);
    for (int p = 0; p < 3; p++) expect_one(n0 + p);
    measure(3);

    // Debounce: bounce, stable high, stable low.
    btn_phase("bounce", 40, 5, 0, 0);
    usr_btn = 1'b0;
    repeat (5) step();
    usr_btn = 1'b1;
    btn_phase("press", 20, 0, 1, 1);
    usr_btn = 1'b0;
    btn_phase("release", 20, 0, 0, 0);

    // Reset mid-period and mid-debounce.
    mode = 2'd1; mode_m = 1;
    wait_pe();
    repeat (30) step();
    usr_btn = 1'b1;
    repeat (6) step();
    reset = 1'b1;
    step();
    chk("midrst_led", int'(led), 0);
    chk("midrst_led_al", int'(led_al), 7);
    chk("midrst_flags", int'({period_end, btn_level, btn_press, rst_n}), 0);
    usr_btn = 1'b0;
    check_rstn_release();
    chk("midrst_no_press", int'(btn_press | btn_level), 0);
    duty_m = '{0, 0, 0};
    wait_pe();
    expect_one((mc + 1) / 256);
    measure(1);

    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rgb_pwm_ctrl.md
RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CHANNELS, 3, number of LED outputs.
- PWM_WIDTH, 8, duty and PWM counter width.
- DEB_CYCLES, 16'd50000, consecutive stable cycles needed to accept a button level.
- RST_CYCLES, 1024, cycles rst_n is held low after reset.
- BLINK_LOG2, 6, blink half-period is 2^BLINK_LOG2 PWM periods.
- ACTIVE_LOW, 0, when 1, led outputs are inverted.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, sole clock.
- reset, in, 1, synchronous, active-high.
- wr_en, in, 1, duty write strobe.
- wr_chan, in, clog2(CHANNELS) (min 1), target channel.
- wr_duty, in, PWM_WIDTH, duty value.
- mode, in, 2, 0 off, 1 static, 2 breathe, 3 blink.
- usr_btn, in, 1, raw asynchronous button.
- led, out, CHANNELS, LED drive.
- btn_level, out, 1, debounced button level.
- btn_press, out, 1, one-cycle press pulse.
- rst_n, out, 1, delayed board reset release.
- period_end, out, 1, pulse on the last cycle of each PWM period.

Function
REQ-003 PWM counter cnt SHALL be PWM_WIDTH bits, increment every cycle, and wrap from 2^PWM_WIDTH-1 to 0.
REQ-004 period_end SHALL be 1 exactly in the cycles where cnt == 2^PWM_WIDTH-1.
REQ-005 Each channel SHALL have a shadow duty register and an active duty register.
REQ-006 A cycle with wr_en=1 and wr_chan<CHANNELS SHALL write wr_duty into the shadow register of channel wr_chan.
REQ-007 A write with wr_chan>=CHANNELS SHALL be ignored, with no state change.
REQ-008 On each period_end cycle, every active register SHALL load its shadow value as it stood before that cycle's write.
REQ-009 A write in a period_end cycle SHALL reach the active register at the following period_end, never mid-period.
REQ-010 The effective duty eff[i] SHALL be selected by mode:
- mode 0: eff = 0.
- mode 1: eff = active[i].
- mode 2: eff = (active[i]*ramp) >> PWM_WIDTH, using a full 2*PWM_WIDTH product.
- mode 3: eff = active[i] when blink_phase=1, else 0.
REQ-011 The led[i] pre-inversion value SHALL be registered (cnt < eff[i]), giving one cycle of latency from cnt.
REQ-012 duty 0 SHALL give constant inactive output; duty 2^PWM_WIDTH-1 SHALL give 2^PWM_WIDTH-1 active cycles per 2^PWM_WIDTH-cycle period.
REQ-013 led SHALL equal the pre-inversion value XOR {CHANNELS{ACTIVE_LOW}}.
REQ-014 ramp (PWM_WIDTH bits) and its direction bit SHALL update only on period_end:
- while counting up, ramp increments; on reaching 2^PWM_WIDTH-1, direction becomes down with no overshoot.
- while counting down, ramp decrements; on reaching 0, direction becomes up.
- ramp updates run in all modes.
REQ-015 Blink period counter (BLINK_LOG2 bits) SHALL increment on period_end; blink_phase SHALL toggle when the counter wraps to 0.
REQ-016 A mode change SHALL take effect at the next cycle's comparison; ramp, blink counter and duty registers SHALL NOT be reset by a mode change.
REQ-017 usr_btn SHALL pass through a 2-flop synchroniser before any use.
REQ-018 The debounce counter SHALL clear whenever the synchronised value equals btn_level.
REQ-019 Otherwise the debounce counter SHALL increment, and btn_level SHALL take the synchronised value in the cycle the count reaches DEB_CYCLES-1.
REQ-020 Any bounce before DEB_CYCLES-1 is reached SHALL restart the debounce count.
REQ-021 btn_press SHALL be 1 for exactly the one cycle after btn_level rises 0->1; a falling btn_level SHALL produce no pulse.
REQ-022 The rst_n counter SHALL count from reset release and drive rst_n=1 from cycle RST_CYCLES after release onward; rst_n SHALL then stay 1 until the next reset.

Reset
REQ-023 While reset=1 at a clock edge, the following SHALL take the values given:
- cnt, shadow, active, ramp, blink counter, blink_phase: 0.
- ramp direction: up.
- synchroniser and debounce counter: 0.
- btn_level, btn_press, period_end: 0.
- rst_n: 0.
- led: {CHANNELS{ACTIVE_LOW}}.
REQ-024 Reset asserted mid-period or mid-debounce SHALL abandon all progress, with no residual pulses.

Verification
REQ-025 Duty sweep: mode=1, write ch0 duty 0x40, run 2 periods -> after first period_end led[0] high 64 of 256 cycles per period; duty 0x00 -> never high; duty 0xFF -> 255 of 256.
REQ-026 Shadow timing: write ch1 0x80 at cnt=10 -> led[1] unchanged until after period_end; write with wr_chan=3 (CHANNELS=3) -> no register changes.
REQ-027 Breathe: mode=2, ch2 duty 0xFF -> ramp reaches 255 after 255 periods and returns to 0 after 510, with high-time tracking (255*ramp)>>8.
REQ-028 Debounce: DEB_CYCLES=8; toggle usr_btn every 5 cycles -> btn_level stays 0; hold high 12 cycles -> btn_level=1 and a single btn_press pulse.
REQ-029 Reset: RST_CYCLES=16, deassert reset -> rst_n low for 16 cycles then high; assert reset mid-period -> led inactive and cnt=0 on the next cycle.
REQ-030 ACTIVE_LOW=1, mode=0 -> all led bits constantly 1.
